// File: rtl/moore_pattern_pkg.sv
// Shared encodings for the Moore pattern generator and detector.
// State enum plus the default 1010 pattern constant.
package moore_pattern_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/moore_pattern_gen_shift_reg.sv
// pattern_shift_reg: parallel load, MSB-first shift-out with zero fill.
// Ports: clk, rst (sync, active-high), load, shift, din, msb.
module pattern_shift_reg #(
  parameter int PATTERN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [PATTERN_W-1:0] din,
  output logic                 msb
);

  logic [PATTERN_W-1:0] sr_q;
  logic [PATTERN_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[PATTERN_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[PATTERN_W-1];

endmodule

// File: rtl/moore_pattern_gen.sv
// Moore pattern generator: valid/ready word in, MSB-first serial out,
// N repetitions with optional idle gap. Ports: in_valid/in_ready/pattern_in/
// repeat_in/abort in; data/data_valid/frame_start/done/sent_count out.
module moore_pattern_gen
  import moore_pattern_pkg::*;
#(
  parameter int PATTERN_W  = 4,
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic [RPT_W-1:0]     repeat_in,
  input  logic                 abort,
  output logic                 data,
  output logic                 data_valid,
  output logic                 frame_start,
  output logic                 done,
  output logic [CNT_W-1:0]     sent_count
);

  localparam int BW = $clog2(PATTERN_W);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e               state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [RPT_W-1:0]     rpt_q, rpt_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dv_q, dv_d;
  logic                 fs_q, fs_d;
  logic                 done_q, done_d;
  logic                 rdy_q, rdy_d;

  logic                 sr_load;
  logic                 sr_shift;
  logic [PATTERN_W-1:0] sr_din;

  logic accept;
  logic last_bit;
  logic last_rpt;
  logic gap_last;

  assign accept   = in_valid & rdy_q & ~abort;
  assign last_bit = (bit_q == BW'(PATTERN_W - 1));
  assign last_rpt = (rpt_q == RPT_W'(1));
  assign gap_last = (GAP_CYCLES > 0) &&
                    (int'(gap_q) == GAP_CYCLES - 1);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    rpt_d    = rpt_q;
    gap_d    = gap_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = pat_q;
    fs_d     = 1'b0;

    if (abort && state_q != S_IDLE) begin
      // Loading zeros clears the serial line immediately.
      state_d = S_IDLE;
      bit_d   = '0;
      gap_d   = '0;
      sr_load = 1'b1;
      sr_din  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_SHIFT;
            pat_d   = pattern_in;
            rpt_d   = (repeat_in == '0) ? RPT_W'(1) : repeat_in;
            bit_d   = '0;
            sr_load = 1'b1;
            sr_din  = pattern_in;
            fs_d    = 1'b1;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            bit_d    = bit_q + BW'(1);
            sr_shift = 1'b1;
          end else begin
            bit_d = '0;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (last_rpt) begin
              // Final shift drains the register to all zeros.
              state_d  = S_DONE;
              sr_shift = 1'b1;
            end else begin
              rpt_d = rpt_q - RPT_W'(1);
              if (GAP_CYCLES == 0) begin
                sr_load = 1'b1;
                fs_d    = 1'b1;
              end else begin
                state_d  = S_GAP;
                gap_d    = '0;
                sr_shift = 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_last) begin
            state_d = S_SHIFT;
            gap_d   = '0;
            sr_load = 1'b1;
            fs_d    = 1'b1;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    dv_d   = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
    rdy_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      rpt_q   <= '0;
      gap_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rpt_q   <= rpt_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      fs_q    <= fs_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  pattern_shift_reg #(
    .PATTERN_W(PATTERN_W)
  ) u_sr (
    .clk  (clk),
    .rst  (rst),
    .load (sr_load),
    .shift(sr_shift),
    .din  (sr_din),
    .msb  (data)
  );

  assign in_ready    = rdy_q;
  assign data_valid  = dv_q;
  assign frame_start = fs_q;
  assign done        = done_q;
  assign sent_count  = cnt_q;

endmodule
